// File: rtl/mux_share_arbiter.sv
// Shares one priority_mux_6to1 between six requesters and hands each beat downstream on valid/ready.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for fixed priority (highest index wins).
module mux_share_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       req,
    output logic [4:0]       mux_sel,
    input  logic [WIDTH-1:0] mux_out,
    output logic [5:0]       gnt,
    output logic [5:0]       ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned N_REQ = 6;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [5:0]       gnt_q, gnt_d;

    logic             hs;
    logic             arb_en;
    logic [5:0]       cand;
    logic             found;
    logic [IDX_W-1:0] win;

    // The owner's own request is masked on its handshake so a lone holder alternates beats.
    assign hs     = (state_q == SEND) & out_ready;
    assign arb_en = rst_n & ((state_q == IDLE) | hs);
    assign cand   = req & ~(hs ? gnt_q : 6'b0);

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (cand[i]) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int unsigned off);
        logic [IDX_W:0] sum;
        sum = (IDX_W+1)'(base) + (IDX_W+1)'(off);
        if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
        end
        return sum[IDX_W-1:0];
    endfunction

    // First requesting index found walking up from ptr, wrapping mod 6.
    always_comb begin
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = wrap_add(ptr_q, i);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (arb_en && found) begin
            ptr_d = wrap_add(win, 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Winner 0 is the mux default input; winner k selects via one-hot bit k-1.
    always_comb begin
        mux_sel = 5'b0;
        if (arb_en && found && (win != '0)) begin
            mux_sel = 5'(1) << (win - IDX_W'(1));
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        if (arb_en && found) begin
            state_d = SEND;
            data_d  = mux_out;
            gnt_d   = 6'(1) << win;
        end else if (hs) begin
            state_d = IDLE;
            gnt_d   = 6'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            gnt_q   <= 6'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = data_q;
    assign gnt       = gnt_q;
    assign ack       = gnt_q & {6{hs}};

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_valid_gnt   : assert property (@(posedge clk) disable iff (!rst_n) out_valid == (gnt_q != 6'b0));

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench for mux_share_arbiter: directed literal checks plus a randomized run
// compared every cycle against a queue-free owner/pointer model of the arbitration rules.
module tb_mux_share_arbiter;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [5:0]       req;
    logic [4:0]       mux_sel;
    logic [WIDTH-1:0] mux_out;
    logic [5:0]       gnt;
    logic [5:0]       ack;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d [6];

    int n_vec = 0;
    int n_err = 0;

    // Model: who owns the current beat (-1 = none), its data, and the round-robin pointer.
    int               m_owner;
    logic [WIDTH-1:0] m_data;
    int               m_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mux_sel   (mux_sel),
        .mux_out   (mux_out),
        .gnt       (gnt),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // priority_mux_6to1: highest set select bit k picks d[k+1], otherwise d[0].
    always_comb begin
        mux_out = d[0];
        for (int k = 0; k < 5; k++) begin
            if (mux_sel[k]) mux_out = d[k+1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [5:0] cands, input int ptr);
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 5; k >= 0; k--) if (cands[k]) return k;
        return (ptr < 0) ? -2 : -1;
`else
        for (int k = 0; k < 6; k++) if (cands[(ptr + k) % 6]) return (ptr + k) % 6;
        return -1;
`endif
    endfunction

    function automatic logic [5:0] model_gnt();
        return (m_owner >= 0) ? 6'(1 << m_owner) : 6'b0;
    endfunction

    function automatic bit model_hs();
        return (m_owner >= 0) && (out_ready === 1'b1);
    endfunction

    function automatic int model_win();
        if (rst_n !== 1'b1) return -1;
        if ((m_owner >= 0) && !model_hs()) return -1;
        return pick(req & ~(model_hs() ? model_gnt() : 6'b0), m_ptr);
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_data  = '0;
        m_ptr   = 0;
    endfunction

    task automatic model_check();
        int         w;
        logic [4:0] es;
        w  = model_win();
        es = (w <= 0) ? 5'b0 : 5'(1 << (w - 1));
        chk("m_valid", 32'(out_valid), 32'(m_owner >= 0));
        chk("m_gnt",   32'(gnt),       32'(model_gnt()));
        chk("m_ack",   32'(ack),       32'(model_hs() ? model_gnt() : 6'b0));
        chk("m_sel",   32'(mux_sel),   32'(es));
        if (m_owner >= 0) chk("m_data", 32'(out_data), 32'(m_data));
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    // Advance one clock; model state moves with the same sampled inputs the DUT sees.
    task automatic tick();
        int w;
        bit hs;
        w  = model_win();
        hs = model_hs();
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            model_reset();
        end else if (w >= 0) begin
            m_data  = d[w];
            m_owner = w;
            m_ptr   = (w + 1) % 6;
        end else if (hs) begin
            m_owner = -1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 6'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_gnt",   32'(gnt),       32'h0);
        chk("rst_ack",   32'(ack),       32'h0);
        chk("rst_sel",   32'(mux_sel),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 6'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) d[i] = WIDTH'(8'h10 + i);
        model_reset();
        @(negedge clk);

        // Single requester 0, first-beat latency.
        do_reset();
        req = 6'b000001; d[0] = 8'h55; out_ready = 1'b1;
        settle();
        chk("t1_sel", 32'(mux_sel), 32'h00);
        tick();
        req = 6'b0;
        settle();
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_data",  32'(out_data),  32'h55);
        chk("t1_gnt",   32'(gnt),       32'h01);
        chk("t1_ack",   32'(ack),       32'h01);
        tick();
        settle();
        chk("t1_idle", 32'(out_valid), 32'h0);

        // Two requesters, back-to-back beats.
        do_reset();
        req = 6'b100100; d[2] = 8'hF0; d[5] = 8'hFF; out_ready = 1'b1;
        settle();
`ifdef ARB_FIXED_PRIORITY_EN
        chk("t2_sel0", 32'(mux_sel), 32'h10);
`else
        chk("t2_sel0", 32'(mux_sel), 32'h02);
`endif
        tick();
        settle();
`ifdef ARB_FIXED_PRIORITY_EN
        chk("t2_data0", 32'(out_data), 32'hFF);
        chk("t2_gnt0",  32'(gnt),      32'h20);
        chk("t2_sel1",  32'(mux_sel),  32'h02);
`else
        chk("t2_data0", 32'(out_data), 32'hF0);
        chk("t2_gnt0",  32'(gnt),      32'h04);
        chk("t2_sel1",  32'(mux_sel),  32'h10);
`endif
        tick();
        req = 6'b0;
        settle();
        chk("t2_valid1", 32'(out_valid), 32'h1);
`ifdef ARB_FIXED_PRIORITY_EN
        chk("t2_data1", 32'(out_data), 32'hF0);
`else
        chk("t2_data1", 32'(out_data), 32'hFF);
`endif
        tick();

        // All six requesting: grant order.
        do_reset();
        req = 6'b111111; out_ready = 1'b1;
        settle();
        tick();
        for (int k = 0; k < 7; k++) begin
            d[$urandom_range(5, 0)] = WIDTH'($urandom);
            settle();
`ifdef ARB_FIXED_PRIORITY_EN
            chk("t3_gnt", 32'(gnt), (k % 2 == 0) ? 32'h20 : 32'h10);
`else
            chk("t3_gnt", 32'(gnt), 32'(1 << (k % 6)));
`endif
            tick();
        end
        req = 6'b0;
        settle();
        tick();

        // Stall with requester 3 granted; its data changes are ignored.
        do_reset();
        req = 6'b001000; d[3] = 8'hA5; out_ready = 1'b0;
        settle();
        tick();
        req = 6'b0;
        for (int k = 0; k < 5; k++) begin
            d[3] = WIDTH'($urandom);
            if (k == 2) req = 6'b000011;
            settle();
            chk("t4_data", 32'(out_data), 32'hA5);
            chk("t4_gnt",  32'(gnt),      32'h08);
            chk("t4_ack",  32'(ack),      32'h00);
            tick();
        end
        req = 6'b0; out_ready = 1'b1;
        settle();
        chk("t4_ack_rel", 32'(ack), 32'h08);
        tick();
        settle();
        chk("t4_idle", 32'(out_valid), 32'h0);

        // Lone requester 1 holding req: one beat every two cycles.
        do_reset();
        req = 6'b000010; out_ready = 1'b1;
        settle();
        tick();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t5_valid", 32'(out_valid), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("t5_ack",   32'(ack),       (k % 2 == 0) ? 32'h02 : 32'h00);
            tick();
        end

        // Reset during a stalled beat.
        do_reset();
        req = 6'b010000; d[4] = 8'h3C; out_ready = 1'b0;
        settle();
        tick();
        settle();
        chk("t6_pre_valid", 32'(out_valid), 32'h1);
        tick();
        do_reset();

        // Randomized traffic checked every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(199, 0) == 0) begin
                do_reset();
            end else begin
                req       = ($urandom_range(3, 0) == 0) ? 6'b0 : 6'($urandom);
                out_ready = ($urandom_range(9, 0) < 7);
                for (int i = 0; i < 6; i++) d[i] = WIDTH'($urandom);
                settle();
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
